// File: rtl/r8051_sfr_pkg.sv
// SFR addresses, SCON bit positions and the shared serial state encoding
// for the 8051-style UART.
package r8051_sfr_pkg;

  localparam logic [7:0] SCON_ADDR = 8'h98;
  localparam logic [7:0] SBUF_ADDR = 8'h99;

  localparam int SCON_REN = 4;
  localparam int SCON_TI  = 1;
  localparam int SCON_RI  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/r8051_uart_rx.sv
// 8N1 receiver: 2-flop input synchronizer, start-bit mid-sample qualification,
// then one sample per bit period. Pulses load for one cycle with a good frame.
//
//  state    | meaning
//  ST_IDLE  | waiting for a synchronized falling edge with ren high
//  ST_START | counting to the middle of the start bit, re-checking it is low
//  ST_DATA  | sampling 8 data bits LSB first, one per bit period
//  ST_STOP  | sampling the stop bit; load only if high and RI is clear
module r8051_uart_rx
  import r8051_sfr_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       ren,
  input  logic       ri,
  output logic       load,
  output logic [7:0] data
);

  localparam logic [15:0] BIT_RELOAD  = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_RELOAD = 16'((CLK_DIV / 2) - 1);

  logic        rxd_s1, rxd_s2, rxd_prev;
  uart_state_e state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [7:0]  shift, shift_nxt;
  logic        fall, tc;

  assign fall = rxd_prev & ~rxd_s2;
  assign tc   = (timer == 16'd0);
  assign data = shift;

  // Synchronize the asynchronous line and keep one cycle of history for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_s1   <= rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
    end
  end

  // Receiver state, bit timer, bit counter and shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      timer   <= 16'd0;
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
    end
  end

  // Next-state logic; dropping ren abandons any frame in progress.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = tc ? timer : timer - 16'd1;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    load        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ren && fall) begin
          state_nxt = ST_START;
          timer_nxt = HALF_RELOAD;
        end
      end
      ST_START: begin
        if (!ren) begin
          state_nxt = ST_IDLE;
        end else if (tc) begin
          if (rxd_s2) begin
            state_nxt = ST_IDLE;
          end else begin
            state_nxt   = ST_DATA;
            timer_nxt   = BIT_RELOAD;
            bit_cnt_nxt = 3'd0;
          end
        end
      end
      ST_DATA: begin
        if (!ren) begin
          state_nxt = ST_IDLE;
        end else if (tc) begin
          shift_nxt = {rxd_s2, shift[7:1]};
          timer_nxt = BIT_RELOAD;
          if (bit_cnt == 3'd7) begin
            state_nxt = ST_STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (!ren) begin
          state_nxt = ST_IDLE;
        end else if (tc) begin
          state_nxt = ST_IDLE;
          load      = rxd_s2 & ~ri;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/r8051_uart.sv
// 8051-style serial port, mode-1-like 8N1 framing: SCON/SBUF SFR decode,
// transmitter and SCON live here, the receiver is a sub-module.
//
//  state    | meaning
//  ST_IDLE  | line high, SBUF write starts a frame
//  ST_START | driving the start bit
//  ST_DATA  | driving 8 data bits LSB first
//  ST_STOP  | driving the stop bit; TI set and back to idle as it ends
module r8051_uart
  import r8051_sfr_pkg::*;
#(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sfr_rd_en,
  input  logic [7:0] sfr_rd_addr,
  output logic [7:0] sfr_rd_byte,
  output logic       sfr_rd_hit,
  input  logic       sfr_wr_en,
  input  logic [7:0] sfr_wr_addr,
  input  logic [7:0] sfr_wr_byte,
  output logic       uart_txd,
  input  logic       uart_rxd,
  output logic       irq
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);

  logic [7:0]  scon, scon_nxt, rx_buf, rx_data;
  logic        rx_load, wr_scon, wr_sbuf, tx_done, txd_nxt, tx_tc;
  uart_state_e tx_state, tx_state_nxt;
  logic [15:0] tx_timer, tx_timer_nxt;
  logic [2:0]  tx_bit_cnt, tx_bit_cnt_nxt;
  logic [7:0]  tx_shift, tx_shift_nxt;

  assign wr_scon = sfr_wr_en && (sfr_wr_addr == SCON_ADDR);
  assign wr_sbuf = sfr_wr_en && (sfr_wr_addr == SBUF_ADDR);
  assign tx_tc   = (tx_timer == 16'd0);

  r8051_uart_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk  (clk),
    .rst  (rst),
    .rxd  (uart_rxd),
    .ren  (scon[SCON_REN]),
    .ri   (scon[SCON_RI]),
    .load (rx_load),
    .data (rx_data)
  );

  // Transmit state, timer, counter, shifter and the registered line.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state   <= ST_IDLE;
      tx_timer   <= 16'd0;
      tx_bit_cnt <= 3'd0;
      tx_shift   <= 8'h00;
      uart_txd   <= 1'b1;
    end else begin
      tx_state   <= tx_state_nxt;
      tx_timer   <= tx_timer_nxt;
      tx_bit_cnt <= tx_bit_cnt_nxt;
      tx_shift   <= tx_shift_nxt;
      uart_txd   <= txd_nxt;
    end
  end

  // Transmit next-state logic; SBUF writes outside idle are dropped.
  always_comb begin
    tx_state_nxt   = tx_state;
    tx_timer_nxt   = tx_tc ? tx_timer : tx_timer - 16'd1;
    tx_bit_cnt_nxt = tx_bit_cnt;
    tx_shift_nxt   = tx_shift;
    txd_nxt        = uart_txd;
    tx_done        = 1'b0;
    case (tx_state)
      ST_IDLE: begin
        txd_nxt = 1'b1;
        if (wr_sbuf) begin
          tx_state_nxt   = ST_START;
          tx_shift_nxt   = sfr_wr_byte;
          tx_timer_nxt   = BIT_RELOAD;
          tx_bit_cnt_nxt = 3'd0;
          txd_nxt        = 1'b0;
        end
      end
      ST_START: begin
        if (tx_tc) begin
          tx_state_nxt = ST_DATA;
          tx_timer_nxt = BIT_RELOAD;
          txd_nxt      = tx_shift[0];
        end
      end
      ST_DATA: begin
        if (tx_tc) begin
          tx_timer_nxt = BIT_RELOAD;
          if (tx_bit_cnt == 3'd7) begin
            tx_state_nxt = ST_STOP;
            txd_nxt      = 1'b1;
          end else begin
            tx_bit_cnt_nxt = tx_bit_cnt + 3'd1;
            tx_shift_nxt   = {1'b0, tx_shift[7:1]};
            txd_nxt        = tx_shift[1];
          end
        end
      end
      ST_STOP: begin
        if (tx_tc) begin
          tx_state_nxt = ST_IDLE;
          tx_done      = 1'b1;
        end
      end
      default: begin
        tx_state_nxt = ST_IDLE;
        txd_nxt      = 1'b1;
      end
    endcase
  end

  // SCON update: CPU write first, hardware flag sets override their own bit.
  always_comb begin
    scon_nxt = scon;
    if (wr_scon) scon_nxt = sfr_wr_byte;
    if (tx_done) scon_nxt[SCON_TI] = 1'b1;
    if (rx_load) scon_nxt[SCON_RI] = 1'b1;
  end

  // SCON, receive buffer and irq; irq follows the flags in the same cycle they set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scon   <= 8'h00;
      rx_buf <= 8'h00;
      irq    <= 1'b0;
    end else begin
      scon <= scon_nxt;
      irq  <= scon_nxt[SCON_TI] | scon_nxt[SCON_RI];
      if (rx_load) rx_buf <= rx_data;
    end
  end

  // Registered SFR read; values are taken before any same-cycle write lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sfr_rd_byte <= 8'h00;
      sfr_rd_hit  <= 1'b0;
    end else if (sfr_rd_en && (sfr_rd_addr == SCON_ADDR)) begin
      sfr_rd_byte <= scon;
      sfr_rd_hit  <= 1'b1;
    end else if (sfr_rd_en && (sfr_rd_addr == SBUF_ADDR)) begin
      sfr_rd_byte <= rx_buf;
      sfr_rd_hit  <= 1'b1;
    end else begin
      sfr_rd_hit  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_r8051_uart.sv
// Self-checking bench for r8051_uart at CLK_DIV=4.
module tb_r8051_uart;

  localparam int CLK_DIV = 4;
  localparam logic [7:0] A_SCON = 8'h98;
  localparam logic [7:0] A_SBUF = 8'h99;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sfr_rd_en = 1'b0;
  logic [7:0] sfr_rd_addr = 8'h00;
  logic [7:0] sfr_rd_byte;
  logic       sfr_rd_hit;
  logic       sfr_wr_en = 1'b0;
  logic [7:0] sfr_wr_addr = 8'h00;
  logic [7:0] sfr_wr_byte = 8'h00;
  logic       uart_txd;
  logic       uart_rxd = 1'b1;
  logic       irq;

  int n_vec = 0;
  int n_err = 0;

  logic       exp_bits[$];
  logic [7:0] exp_q[$];

  r8051_uart #(.CLK_DIV(CLK_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .sfr_rd_en   (sfr_rd_en),
    .sfr_rd_addr (sfr_rd_addr),
    .sfr_rd_byte (sfr_rd_byte),
    .sfr_rd_hit  (sfr_rd_hit),
    .sfr_wr_en   (sfr_wr_en),
    .sfr_wr_addr (sfr_wr_addr),
    .sfr_wr_byte (sfr_wr_byte),
    .uart_txd    (uart_txd),
    .uart_rxd    (uart_rxd),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic sfr_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    sfr_wr_en = 1'b1; sfr_wr_addr = a; sfr_wr_byte = d;
    @(negedge clk);
    sfr_wr_en = 1'b0;
  endtask

  task automatic sfr_read(input logic [7:0] a, output logic [7:0] d, output logic h);
    @(negedge clk);
    sfr_rd_en = 1'b1; sfr_rd_addr = a;
    @(negedge clk);
    sfr_rd_en = 1'b0;
    d = sfr_rd_byte; h = sfr_rd_hit;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      uart_rxd = fr[i];
      repeat (CLK_DIV - 1) @(negedge clk);
    end
    @(negedge clk);
    uart_rxd = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_scon(input string nm, input logic [7:0] e);
    logic [7:0] d; logic h;
    sfr_read(A_SCON, d, h);
    n_vec++;
    if (d !== e || h !== 1'b1) begin
      n_err++;
      $display("FAIL %s: scon=%h hit=%b, required scon=%h hit=1", nm, d, h, e);
    end
  endtask

  task automatic check_sbuf(input string nm);
    logic [7:0] d; logic h; logic [7:0] e;
    sfr_read(A_SBUF, d, h);
    e = exp_q.pop_front();
    n_vec++;
    if (d !== e || h !== 1'b1) begin
      n_err++;
      $display("FAIL %s: sbuf=%h hit=%b, required sbuf=%h hit=1", nm, d, h, e);
    end
  endtask

  // mode 0: plain frame; 1: extra SBUF write mid-frame; 2: SCON=0x10 written as TI sets
  task automatic run_tx_frame(input string nm, input logic [7:0] b, input int mode);
    int first_irq;
    logic e;
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
    exp_bits.push_back(1'b1);
    @(negedge clk);
    sfr_wr_en = 1'b1; sfr_wr_addr = A_SBUF; sfr_wr_byte = b;
    @(negedge clk);
    sfr_wr_en = 1'b0;
    first_irq = -1;
    for (int c = 0; c < 90; c++) begin
      if (c == 0) begin
        n_vec++;
        if (uart_txd !== 1'b0) begin
          n_err++;
          $display("FAIL %s start latency: txd=%b required 0", nm, uart_txd);
        end
      end
      if (c % 4 == 1) begin
        e = (c < 40) ? exp_bits.pop_front() : 1'b1;
        n_vec++;
        if (uart_txd !== e) begin
          n_err++;
          $display("FAIL %s bit at cycle %0d: txd=%b required %b", nm, c, uart_txd, e);
        end
      end
      if (irq === 1'b1 && first_irq < 0) first_irq = c;
      if (mode == 1 && c == 10) begin
        sfr_wr_en = 1'b1; sfr_wr_addr = A_SBUF; sfr_wr_byte = 8'hAA;
      end
      if (mode == 2 && c == 39) begin
        sfr_wr_en = 1'b1; sfr_wr_addr = A_SCON; sfr_wr_byte = 8'h10;
      end
      if (c == 11 || c == 40) sfr_wr_en = 1'b0;
      @(negedge clk);
    end
    n_vec++;
    if (first_irq != 40) begin
      n_err++;
      $display("FAIL %s irq timing: irq first seen at cycle %0d required 40", nm, first_irq);
    end
    check_scon({nm, " scon"}, (mode == 2) ? 8'h12 : 8'h02);
    sfr_write(A_SCON, 8'h00);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (uart_txd !== 1'b1 || irq !== 1'b0 || sfr_rd_hit !== 1'b0 || sfr_rd_byte !== 8'h00) begin
      n_err++;
      $display("FAIL reset outputs: txd=%b irq=%b hit=%b byte=%h required 1 0 0 00",
               uart_txd, irq, sfr_rd_hit, sfr_rd_byte);
    end
    rst = 1'b1;
    check_scon("reset scon", 8'h00);
    exp_q.push_back(8'h00);
    check_sbuf("reset sbuf");
  endtask

  task automatic test_sfr_decode();
    logic [7:0] d; logic h;
    sfr_write(8'h9A, 8'hFF);
    sfr_write(A_SCON, 8'hE0);
    check_scon("scon storage bits", 8'hE0);
    sfr_read(8'h80, d, h);
    n_vec++;
    if (h !== 1'b0 || d !== 8'hE0) begin
      n_err++;
      $display("FAIL undecoded read: byte=%h hit=%b required byte=e0 hit=0", d, h);
    end
    @(negedge clk);
    sfr_rd_en = 1'b1; sfr_rd_addr = A_SCON;
    sfr_wr_en = 1'b1; sfr_wr_addr = A_SCON; sfr_wr_byte = 8'h0C;
    @(negedge clk);
    sfr_rd_en = 1'b0; sfr_wr_en = 1'b0;
    n_vec++;
    if (sfr_rd_byte !== 8'hE0 || sfr_rd_hit !== 1'b1) begin
      n_err++;
      $display("FAIL read-during-write: byte=%h hit=%b required e0 1", sfr_rd_byte, sfr_rd_hit);
    end
    check_scon("scon after rd/wr", 8'h0C);
    sfr_write(A_SCON, 8'h00);
  endtask

  task automatic test_cpu_set();
    sfr_write(A_SCON, 8'h01);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL cpu set RI irq: irq=%b required 1", irq);
    end
    sfr_write(A_SCON, 8'h00);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++;
      $display("FAIL cpu clear irq: irq=%b required 0", irq);
    end
  endtask

  task automatic test_tx();
    run_tx_frame("tx55", 8'h55, 0);
    run_tx_frame("txC3", 8'hC3, 0);
  endtask

  task automatic test_back_to_back();
    run_tx_frame("tx55 busy write", 8'h55, 1);
  endtask

  task automatic test_priority();
    run_tx_frame("ti priority", 8'h5A, 2);
  endtask

  task automatic test_rx();
    sfr_write(A_SCON, 8'h10);
    exp_q.push_back(8'hA3);
    send_rx(8'hA3, 1'b1);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++;
      $display("FAIL rx irq: irq=%b required 1", irq);
    end
    check_scon("rx scon RI", 8'h11);
    check_sbuf("rx A3");
    exp_q.push_back(8'hA3);
    send_rx(8'h11, 1'b1);
    check_sbuf("rx overrun keeps A3");
    sfr_write(A_SCON, 8'h10);
  endtask

  task automatic test_rx_errors();
    send_rx(8'h5C, 1'b0);
    check_scon("rx bad stop", 8'h10);
    exp_q.push_back(8'hA3);
    check_sbuf("rx bad stop sbuf");
    @(negedge clk); uart_rxd = 1'b0;
    repeat (2) @(negedge clk); uart_rxd = 1'b1;
    repeat (30) @(negedge clk);
    check_scon("rx glitch", 8'h10);
    exp_q.push_back(8'h3C);
    send_rx(8'h3C, 1'b1);
    check_scon("rx after glitch", 8'h11);
    check_sbuf("rx 3C");
    sfr_write(A_SCON, 8'h10);
    fork
      send_rx(8'hF0, 1'b1);
      begin
        repeat (15) @(negedge clk);
        sfr_write(A_SCON, 8'h00);
        sfr_write(A_SCON, 8'h10);
      end
    join
    check_scon("rx ren drop", 8'h10);
    exp_q.push_back(8'h3C);
    check_sbuf("rx ren drop sbuf");
  endtask

  task automatic test_reset_mid();
    int bad;
    sfr_write(A_SCON, 8'h12);
    @(negedge clk);
    sfr_wr_en = 1'b1; sfr_wr_addr = A_SBUF; sfr_wr_byte = 8'h00;
    @(negedge clk);
    sfr_wr_en = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++;
    if (uart_txd !== 1'b1 || irq !== 1'b0) begin
      n_err++;
      $display("FAIL async reset mid-frame: txd=%b irq=%b required 1 0", uart_txd, irq);
    end
    @(negedge clk);
    rst = 1'b1;
    check_scon("scon after reset", 8'h00);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      if (uart_txd !== 1'b1 || irq !== 1'b0) bad++;
      @(negedge clk);
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL idle after reset: %0d bad cycles required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_sfr_decode();
    test_cpu_set();
    test_tx();
    test_back_to_back();
    test_priority();
    test_rx();
    test_rx_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
